// File: rtl/debug_pattern_checker_pkg.sv
//==============================================================================
// Module : ColorUtilities (package)
// Brief  : Control codes, checker state encoding and the colour-bar table
//          shared by the pattern generator and the debug pattern checker.
// Rev    : 1.0 - initial release
//==============================================================================
`default_nettype none

package ColorUtilities;

    localparam logic [15:0] c_CTRL_FRAME_START = 16'h0001;
    localparam logic [15:0] c_CTRL_ROW_END     = 16'h0002;
    localparam logic [15:0] c_CTRL_FRAME_END   = 16'h0003;

    typedef logic [15:0] rgb565_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RECEIVE = 2'd1,
        ST_DONE    = 2'd2
    } checker_state_e;

    // Bar index to RGB565; the first ten entries are the standard bar set.
    function automatic rgb565_t get_rgb_color(input logic [3:0] bar_idx);
        rgb565_t color;
        case (bar_idx)
            4'd0:    color = 16'hFFFF;
            4'd1:    color = 16'hFFE0;
            4'd2:    color = 16'h07FF;
            4'd3:    color = 16'h07E0;
            4'd4:    color = 16'hF81F;
            4'd5:    color = 16'hF800;
            4'd6:    color = 16'h001F;
            4'd7:    color = 16'h0000;
            4'd8:    color = 16'h8410;
            4'd9:    color = 16'hFD20;
            4'd10:   color = 16'h7BEF;
            4'd11:   color = 16'hAFE5;
            4'd12:   color = 16'h780F;
            4'd13:   color = 16'h03E0;
            4'd14:   color = 16'h000F;
            default: color = 16'h7800;
        endcase
        return color;
    endfunction

endpackage

`default_nettype wire

// File: rtl/debug_pattern_checker_color_lookup.sv
//==============================================================================
// Module : pattern_color_lookup
// Brief  : Combinational expected-colour lookup: column in, RGB565 out.
// Rev    : 1.0 - initial release
//==============================================================================
`default_nettype none

module pattern_color_lookup
    import ColorUtilities::*;
#(
    parameter int FRAME_WIDTH    = 640,
    parameter int NUM_COLOR_BARS = 10
) (
    input  logic [11:0] column_i,
    output logic [15:0] color_o
);

    localparam int c_BAR_WIDTH = FRAME_WIDTH / NUM_COLOR_BARS;

    logic [31:0] w_column;
    logic [3:0]  w_bar_idx;

    always_comb begin
        w_column  = {20'd0, column_i};
        w_bar_idx = 4'(w_column / 32'(c_BAR_WIDTH));
        if (w_column >= 32'(FRAME_WIDTH)) begin
            color_o = 16'h0000;
        end else begin
            color_o = get_rgb_color(w_bar_idx);
        end
    end

endmodule

`default_nettype wire

// File: rtl/debug_pattern_checker.sv
//==============================================================================
// Module : debug_pattern_checker
// Brief  : Consumes a colour-bar video stream from a 17-bit FIFO and reports
//          frame totals plus sticky pixel, geometry and sequence errors.
// Rev    : 1.0 - initial release
//==============================================================================
`default_nettype none

module debug_pattern_checker
    import ColorUtilities::*;
#(
    parameter int FRAME_WIDTH    = 640,
    parameter int FRAME_HEIGHT   = 480,
    parameter int NUM_COLOR_BARS = 10,
    parameter bit CHECK_PIXELS   = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        queue_empty,
    input  logic [16:0] queue_data,
    output logic        queue_rd_en,
    output logic        queue_rd_clk,
    output logic        frame_done,
    output logic [31:0] pixel_count,
    output logic [15:0] row_count,
    output logic        pixel_error,
    output logic        geometry_error,
    output logic        sequence_error
);

    localparam logic [11:0] c_WIDTH12  = 12'(FRAME_WIDTH);
    localparam logic [15:0] c_HEIGHT16 = 16'(FRAME_HEIGHT);

    checker_state_e state_q, state_d;
    logic        valid_q, valid_d;
    logic [11:0] col_q, col_d;
    logic [15:0] row_q, row_d;
    logic [31:0] run_q, run_d;
    logic [31:0] pix_cnt_q, pix_cnt_d;
    logic [15:0] row_cnt_q, row_cnt_d;
    logic        pix_err_q, pix_err_d;
    logic        geo_err_q, geo_err_d;
    logic        seq_err_q, seq_err_d;

    logic        w_is_ctrl;
    logic [15:0] w_code;
    logic        w_pix_mismatch;

    assign w_is_ctrl = queue_data[16];
    assign w_code    = queue_data[15:0];

    generate
        if (CHECK_PIXELS) begin : g_pix_check
            logic [15:0] w_expected;
            pattern_color_lookup #(
                .FRAME_WIDTH    (FRAME_WIDTH),
                .NUM_COLOR_BARS (NUM_COLOR_BARS)
            ) u_lookup (
                .column_i (col_q),
                .color_o  (w_expected)
            );
            assign w_pix_mismatch = (w_code != w_expected);
        end else begin : g_no_pix_check
            assign w_pix_mismatch = 1'b0;
        end
    endgenerate

    assign queue_rd_clk = clk;
    assign queue_rd_en  = reset_n && !queue_empty && (state_q != ST_DONE);
    assign frame_done   = (state_q == ST_DONE);

    assign pixel_count    = pix_cnt_q;
    assign row_count      = row_cnt_q;
    assign pixel_error    = pix_err_q;
    assign geometry_error = geo_err_q;
    assign sequence_error = seq_err_q;

    // A word fetched while entering DONE stays valid until IDLE consumes it.
    assign valid_d = queue_rd_en || ((state_q == ST_DONE) && valid_q);

    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        row_d     = row_q;
        run_d     = run_q;
        pix_cnt_d = pix_cnt_q;
        row_cnt_d = row_cnt_q;
        pix_err_d = pix_err_q;
        geo_err_d = geo_err_q;
        seq_err_d = seq_err_q;

        case (state_q)
            ST_IDLE: begin
                if (valid_q) begin
                    if (w_is_ctrl && (w_code == c_CTRL_FRAME_START)) begin
                        state_d = ST_RECEIVE;
                        col_d   = 12'd0;
                        row_d   = 16'd0;
                        run_d   = 32'd0;
                    end else begin
                        seq_err_d = 1'b1;
                    end
                end
            end

            ST_RECEIVE: begin
                if (valid_q) begin
                    if (w_is_ctrl) begin
                        case (w_code)
                            c_CTRL_FRAME_START: begin
                                seq_err_d = 1'b1;
                                col_d     = 12'd0;
                                row_d     = 16'd0;
                                run_d     = 32'd0;
                            end
                            c_CTRL_ROW_END: begin
                                if (col_q != c_WIDTH12) begin
                                    geo_err_d = 1'b1;
                                end
                                row_d = row_q + 16'd1;
                                col_d = 12'd0;
                            end
                            c_CTRL_FRAME_END: begin
                                if ((row_q != c_HEIGHT16) || (col_q != 12'd0)) begin
                                    geo_err_d = 1'b1;
                                end
                                pix_cnt_d = run_q;
                                row_cnt_d = row_q;
                                state_d   = ST_DONE;
                            end
                            default: begin
                                seq_err_d = 1'b1;
                            end
                        endcase
                    end else begin
                        if (w_pix_mismatch) begin
                            pix_err_d = 1'b1;
                        end
                        if (col_q != 12'hFFF) begin
                            col_d = col_q + 12'd1;
                        end
                        if (run_q != 32'hFFFF_FFFF) begin
                            run_d = run_q + 32'd1;
                        end
                    end
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            valid_q   <= 1'b0;
            col_q     <= 12'd0;
            row_q     <= 16'd0;
            run_q     <= 32'd0;
            pix_cnt_q <= 32'd0;
            row_cnt_q <= 16'd0;
            pix_err_q <= 1'b0;
            geo_err_q <= 1'b0;
            seq_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            valid_q   <= valid_d;
            col_q     <= col_d;
            row_q     <= row_d;
            run_q     <= run_d;
            pix_cnt_q <= pix_cnt_d;
            row_cnt_q <= row_cnt_d;
            pix_err_q <= pix_err_d;
            geo_err_q <= geo_err_d;
            seq_err_q <= seq_err_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_debug_pattern_checker.sv
//==============================================================================
// Module : tb_debug_pattern_checker
// Brief  : Drives colour-bar frames through a modelled registered-output FIFO
//          and checks the checker against a word-stream reference model.
// Rev    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_debug_pattern_checker;

    localparam int W    = 640;
    localparam int H    = 20;
    localparam int BARW = 64;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        queue_empty = 1'b1;
    logic [16:0] queue_data = 17'd0;
    logic        queue_rd_en, queue_rd_clk, frame_done;
    logic [31:0] pixel_count;
    logic [15:0] row_count;
    logic        pixel_error, geometry_error, sequence_error;

    debug_pattern_checker #(
        .FRAME_WIDTH    (W),
        .FRAME_HEIGHT   (H),
        .NUM_COLOR_BARS (10),
        .CHECK_PIXELS   (1'b1)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .queue_empty    (queue_empty),
        .queue_data     (queue_data),
        .queue_rd_en    (queue_rd_en),
        .queue_rd_clk   (queue_rd_clk),
        .frame_done     (frame_done),
        .pixel_count    (pixel_count),
        .row_count      (row_count),
        .pixel_error    (pixel_error),
        .geometry_error (geometry_error),
        .sequence_error (sequence_error)
    );

    always #5 clk = ~clk;

    logic [15:0] tbl [0:9] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0, 16'hF81F,
                               16'hF800, 16'h001F, 16'h0000, 16'h8410, 16'hFD20};

    typedef struct {
        logic [31:0] pc;
        logic [15:0] rc;
    } frame_res_t;

    logic [16:0] fifo [$];
    frame_res_t  exp_frames [$];
    frame_res_t  fr;
    int          n_checks = 0;
    int          n_fail = 0;
    int          frames_seen = 0;
    int          stall_mode = 0;
    bit          tog = 1'b0;
    bit          prev_done = 1'b0;

    // Reference model state: what the word stream seen so far implies.
    bit          m_recv, m_pix, m_geo, m_seq;
    int          m_col, m_row;
    longint      m_pc;
    logic [31:0] exp_pc = 32'd0;
    logic [15:0] exp_rc = 16'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] exp_color(input int col);
        if (col >= W) return 16'h0000;
        return tbl[col / BARW];
    endfunction

    task automatic model_reset();
        m_recv = 0; m_pix = 0; m_geo = 0; m_seq = 0;
        m_col = 0; m_row = 0; m_pc = 0;
        exp_pc = 32'd0; exp_rc = 16'd0;
        exp_frames.delete();
    endtask

    task automatic model_word(input logic [16:0] w);
        frame_res_t r;
        if (w[16]) begin
            if (w[15:0] == 16'h0001) begin
                if (m_recv) m_seq = 1;
                m_recv = 1; m_col = 0; m_row = 0; m_pc = 0;
            end else if (!m_recv) begin
                m_seq = 1;
            end else if (w[15:0] == 16'h0002) begin
                if (m_col != W) m_geo = 1;
                m_row = m_row + 1; m_col = 0;
            end else if (w[15:0] == 16'h0003) begin
                if (m_row != H || m_col != 0) m_geo = 1;
                r.pc = 32'(m_pc); r.rc = 16'(m_row);
                exp_frames.push_back(r);
                m_recv = 0;
            end else begin
                m_seq = 1;
            end
        end else if (m_recv) begin
            if (w[15:0] != exp_color(m_col)) m_pix = 1;
            if (m_col < 4095) m_col = m_col + 1;
            if (m_pc < 64'hFFFF_FFFF) m_pc = m_pc + 1;
        end else begin
            m_seq = 1;
        end
    endtask

    // FIFO with registered output: a read at an edge presents the word after it.
    always @(posedge clk) begin
        bit          rd_s;
        bit          st;
        logic [16:0] w;
        rd_s = queue_rd_en;
        #1;
        if (rd_s) begin
            if (fifo.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL read_on_empty: actual read expected none at %0t", $time);
            end else begin
                w = fifo.pop_front();
                queue_data = w;
                model_word(w);
            end
        end
        tog = !tog;
        case (stall_mode)
            1:       st = tog;
            2:       st = ($urandom_range(15) == 0);
            default: st = 1'b0;
        endcase
        queue_empty = (fifo.size() == 0) || st;
    end

    always @(negedge clk) begin
        if (reset_n) begin
            check("rd_en_rule", {31'd0, queue_rd_en}, {31'd0, (!queue_empty && !frame_done)});
            if (frame_done) begin
                frames_seen++;
                check("frame_done_single", {31'd0, prev_done}, 32'd0);
                if (exp_frames.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL unexpected_frame_done: actual pulse expected none at %0t", $time);
                end else begin
                    fr = exp_frames.pop_front();
                    exp_pc = fr.pc;
                    exp_rc = fr.rc;
                end
            end
            check("pixel_count", pixel_count, exp_pc);
            check("row_count", {16'd0, row_count}, {16'd0, exp_rc});
        end
        prev_done = frame_done;
    end

    task automatic do_reset(input int cycles);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        fifo.delete();
        model_reset();
        repeat (cycles) @(posedge clk);
        #2;
        reset_n = 1'b1;
        #1;
        check("rst_pixel_count", pixel_count, 32'd0);
        check("rst_row_count", {16'd0, row_count}, 32'd0);
        check("rst_flags", {29'd0, pixel_error, geometry_error, sequence_error}, 32'd0);
        check("rst_frame_done", {31'd0, frame_done}, 32'd0);
        check("rst_rd_en", {31'd0, queue_rd_en}, 32'd0);
    endtask

    task automatic push_pixels(input int n);
        for (int c = 0; c < n; c++) fifo.push_back({1'b0, tbl[c / BARW]});
    endtask

    task automatic push_frame(input int flip_row, input int flip_col, input int short_row);
        logic [15:0] p;
        int          n;
        fifo.push_back({1'b1, 16'h0001});
        for (int r = 0; r < H; r++) begin
            n = (r == short_row) ? W - 1 : W;
            for (int c = 0; c < n; c++) begin
                p = tbl[c / BARW];
                if (r == flip_row && c == flip_col) p = 16'hFFFF;
                fifo.push_back({1'b0, p});
            end
            fifo.push_back({1'b1, 16'h0002});
        end
        fifo.push_back({1'b1, 16'h0003});
    endtask

    task automatic drain(input string name);
        int budget;
        budget = 40000;
        while (fifo.size() != 0 && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        if (budget == 0) begin
            n_checks++; n_fail++;
            $display("FAIL %s_drain_timeout: actual %0d words left expected 0", name, fifo.size());
        end
        repeat (6) @(posedge clk);
        #3;
    endtask

    task automatic check_model(input string name, input int f0);
        check({name, "_pix_err_model"}, {31'd0, pixel_error}, {31'd0, m_pix});
        check({name, "_geo_err_model"}, {31'd0, geometry_error}, {31'd0, m_geo});
        check({name, "_seq_err_model"}, {31'd0, sequence_error}, {31'd0, m_seq});
        check({name, "_frames_pending"}, exp_frames.size(), 32'd0);
        if (f0 < 0) check({name, "_frames_nonneg"}, {31'd0, frames_seen < 0}, 32'd0);
    endtask

    task automatic check_lit(input string name, input int f0, input logic [31:0] pc,
                             input logic [15:0] rc, input logic [2:0] flags);
        check_model(name, f0);
        check({name, "_frames"}, frames_seen - f0, 32'd1);
        check({name, "_pc_lit"}, pixel_count, pc);
        check({name, "_rc_lit"}, {16'd0, row_count}, {16'd0, rc});
        check({name, "_flags_lit"}, {29'd0, pixel_error, geometry_error, sequence_error}, {29'd0, flags});
    endtask

    initial begin
        int          f0;
        int          r;
        logic [16:0] w;

        do_reset(3);

        // Reset in the middle of row 10, then a full frame with a bursty source.
        stall_mode = 0;
        fifo.push_back({1'b1, 16'h0001});
        for (int i = 0; i < 10; i++) begin
            push_pixels(W);
            fifo.push_back({1'b1, 16'h0002});
        end
        push_pixels(300);
        drain("pre_reset");
        do_reset(1);
        stall_mode = 1;
        f0 = frames_seen;
        push_frame(-1, -1, -1);
        drain("clean_toggled");
        check_lit("clean_toggled", f0, 32'd12800, 16'd20, 3'b000);

        // Single corrupted pixel at row 5, column 130.
        do_reset(1);
        stall_mode = 2;
        f0 = frames_seen;
        push_frame(5, 130, -1);
        drain("flip");
        check_lit("flip", f0, 32'd12800, 16'd20, 3'b100);

        // Row 3 one pixel short.
        do_reset(1);
        stall_mode = 0;
        f0 = frames_seen;
        push_frame(-1, -1, 3);
        drain("short_row");
        check_lit("short_row", f0, 32'd12799, 16'd20, 3'b010);

        // Frame restarted after 100 pixels.
        do_reset(1);
        f0 = frames_seen;
        fifo.push_back({1'b1, 16'h0001});
        push_pixels(100);
        push_frame(-1, -1, -1);
        drain("restart");
        check_lit("restart", f0, 32'd12800, 16'd20, 3'b001);

        // Random word soup: short frames, stray codes, back-to-back control words.
        do_reset(1);
        stall_mode = 2;
        f0 = frames_seen;
        fifo.push_back({1'b1, 16'h0001});
        for (int i = 0; i < 800; i++) begin
            r = $urandom_range(99);
            if (r < 5)       w = {1'b1, 16'h0001};
            else if (r < 12) w = {1'b1, 16'h0002};
            else if (r < 16) w = {1'b1, 16'h0003};
            else if (r < 18) w = {1'b1, 16'($urandom_range(9, 4))};
            else if (r < 60) w = {1'b0, tbl[$urandom_range(9)]};
            else             w = {1'b0, 16'($urandom)};
            fifo.push_back(w);
        end
        drain("random");
        check_model("random", f0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/debug_pattern_checker.md
DEBUG_PATTERN_CHECKER -- requirements
Module: debug_pattern_checker

Interface
REQ-001 SHALL have parameter FRAME_WIDTH, default 640, meaning pixels per row.
REQ-002 SHALL have parameter FRAME_HEIGHT, default 480, meaning rows per frame.
REQ-003 SHALL have parameter NUM_COLOR_BARS, default 10, meaning vertical bars across the row; FRAME_WIDTH divisible by it.
REQ-004 SHALL have parameter CHECK_PIXELS, default 1'b1, meaning enable per-pixel colour compare.
REQ-005 SHALL have port clk, input, 1, meaning the single clock; all logic on its rising edge.
REQ-006 SHALL have port reset_n, input, 1, meaning synchronous active-low reset.
REQ-007 SHALL have port queue_empty, input, 1, meaning source FIFO empty.
REQ-008 SHALL have port queue_data, input, 17, meaning FIFO Q: bit16 = control flag, [15:0] = RGB565 pixel or control code.
REQ-009 SHALL have port queue_rd_en, output, 1, meaning FIFO read strobe.
REQ-010 SHALL have port queue_rd_clk, output, 1, meaning FIFO read clock, driven directly from clk.
REQ-011 SHALL have port frame_done, output, 1, meaning one-cycle pulse at frame end.
REQ-012 SHALL have ports pixel_count (output, 32) and row_count (output, 16), meaning totals for the last frame, held until the next frame_done.
REQ-013 SHALL have ports pixel_error, geometry_error, sequence_error, each output, 1, meaning sticky error flags.

Function
REQ-014 SHALL treat words with bit16=1 as control: 16'h0001 FRAME_START, 16'h0002 ROW_END, 16'h0003 FRAME_END; other codes raise sequence_error and are ignored.
REQ-015 SHALL drive queue_rd_en = !queue_empty && state != DONE; no read when empty.
REQ-016 SHALL treat queue_data as valid exactly one cycle after a cycle with queue_rd_en=1 (registered FIFO output).
REQ-017 SHALL implement states IDLE, RECEIVE, DONE.
REQ-018 IDLE: discard pixels and ROW_END/FRAME_END (each sets sequence_error); FRAME_START -> RECEIVE, clearing column and row counters and the running pixel counter.
REQ-019 RECEIVE: each pixel increments column and running pixel counter (32-bit, saturating at all-ones).
REQ-020 RECEIVE, ROW_END: set geometry_error if column != FRAME_WIDTH; row increments; column clears.
REQ-021 RECEIVE, FRAME_END: set geometry_error if row != FRAME_HEIGHT or column != 0; latch pixel_count/row_count; -> DONE.
REQ-022 RECEIVE, FRAME_START: set sequence_error; restart frame as in REQ-018 without pulsing frame_done.
REQ-023 DONE: frame_done=1 for exactly that cycle, queue_rd_en=0; -> IDLE next cycle; a word already in flight from the prior read is processed in IDLE.
REQ-024 Expected colour SHALL be bar index column/(FRAME_WIDTH/NUM_COLOR_BARS) mapped through the shared colour table; columns >= FRAME_WIDTH expect 16'h0000.
REQ-025 When CHECK_PIXELS=1, a pixel mismatch SHALL set pixel_error; comparison uses column before increment.
REQ-026 Pixels beyond FRAME_WIDTH in a row SHALL be counted and set geometry_error at ROW_END; column counter saturates at 2^12-1.
REQ-027 Error flags SHALL be sticky, cleared only by reset.

Reset
REQ-028 On reset_n=0 at a clock edge: state=IDLE, queue_rd_en=0, frame_done=0, all counters, pixel_count, row_count, error flags and the data-valid register = 0, regardless of frame in progress.
REQ-029 After reset release the first accepted frame SHALL begin only at a new FRAME_START.

Structure
REQ-030 Control codes, state enum and the bar-colour table/get_rgb_color function SHALL live in the shared ColorUtilities package, reused by the pattern generator.
REQ-031 Expected-colour lookup SHALL be one combinational sub-module, pattern_color_lookup (column in, RGB565 out).

Verification
REQ-032 640x20 frame from the pattern generator through the 17-bit FIFO -> one frame_done, pixel_count=12800, row_count=20, all errors 0.
REQ-033 Same frame with pixel (row 5, column 130) flipped to 16'hFFFF -> pixel_error=1, geometry_error=0, pixel_count=12800.
REQ-034 Row 3 with 639 pixels then ROW_END -> geometry_error=1; pixel_count=12799.
REQ-035 Second FRAME_START after 100 pixels, then full frame -> sequence_error=1, one frame_done, pixel_count=12800.
REQ-036 reset_n low for one cycle mid-row 10, then full frame -> counters 0 after reset, flags 0, next frame reports 12800/20.
REQ-037 queue_empty toggled every other cycle during a frame -> no read while empty, results identical to REQ-032.
